// File: rtl/event_indicator_if.sv
// Event-indicator bus: event ticks and overflow clear in, indicator and queue status out.
// The master modport is the controlling logic; the slave modport is the indicator block.
interface event_indicator_if #(
  parameter int unsigned PEND_W = 4
);
  logic              tick_in;
  logic              clr_ovf;
  logic              led;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              ovf;

  modport master (
    output tick_in,
    output clr_ovf,
    input  led,
    input  busy,
    input  pending,
    input  ovf
  );

  modport slave (
    input  tick_in,
    input  clr_ovf,
    output led,
    output busy,
    output pending,
    output ovf
  );
endinterface

// File: rtl/event_indicator.sv
// Turns single-cycle event ticks into fixed-length visible pulses with queued replay.
// Optional build macro EVT_RETRIGGER_EN: tick_in during ON restarts the ON phase instead of queueing.
module event_indicator #(
  parameter int unsigned CLK_DIV   = 32'd500000,
  parameter int unsigned ON_TICKS  = 32'd20,
  parameter int unsigned GAP_TICKS = 32'd10,
  parameter int unsigned PEND_W    = 32'd4
) (
  input  logic             clk,
  input  logic             rst,
  event_indicator_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [31:0]       PRESC_MAX   = 32'(CLK_DIV - 32'd1);
  localparam logic [15:0]       ON_LIM      = 16'(ON_TICKS - 32'd1);
  localparam logic [15:0]       GAP_LIM     = (GAP_TICKS > 32'd0) ? 16'(GAP_TICKS - 32'd1) : 16'd0;
  localparam state_t            ST_AFTER_ON = (GAP_TICKS > 32'd0) ? ST_GAP : ST_IDLE;
  localparam logic [PEND_W-1:0] PEND_MAX    = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ZERO   = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE    = PEND_W'(1);

  state_t            r_state;
  logic [31:0]       r_presc;
  logic [15:0]       r_dur;
  logic [PEND_W-1:0] r_pend;
  logic              r_ovf;

  state_t            w_state_nxt;
  logic              w_restart;
  logic              w_phase_clr;
  logic              w_slow_tick;
  logic              w_pend_nz;
  logic              w_inc;
  logic              w_dec;
  logic [PEND_W-1:0] w_pend_nxt;
  logic              w_ovf_nxt;

  assign w_slow_tick = (r_presc == PRESC_MAX);
  assign w_pend_nz   = (r_pend != PEND_ZERO);

  // Next-state selection; retrigger (when built in) outranks end of ON phase.
  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pend_nz || bus.tick_in) begin
          w_state_nxt = ST_ON;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ON: begin
`ifdef EVT_RETRIGGER_EN
        if (bus.tick_in) begin
          w_state_nxt = ST_ON;
          w_restart   = 1'b1;
        end else if (w_slow_tick && (r_dur == ON_LIM)) begin
          w_state_nxt = ST_AFTER_ON;
        end else begin
          w_state_nxt = ST_ON;
        end
`else
        if (w_slow_tick && (r_dur == ON_LIM)) begin
          w_state_nxt = ST_AFTER_ON;
        end else begin
          w_state_nxt = ST_ON;
        end
`endif
      end
      ST_GAP: begin
        if (w_slow_tick && (r_dur == GAP_LIM)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_GAP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_phase_clr = (w_state_nxt != r_state) || w_restart || (r_state == ST_IDLE);

  // Pending-queue arithmetic: a simultaneous increment and decrement cancel out.
  always_comb begin
`ifdef EVT_RETRIGGER_EN
    w_inc = bus.tick_in && ((r_state == ST_GAP) || ((r_state == ST_IDLE) && w_pend_nz));
`else
    w_inc = bus.tick_in && ((r_state == ST_ON) || (r_state == ST_GAP) ||
                            ((r_state == ST_IDLE) && w_pend_nz));
`endif
    w_dec      = (r_state == ST_IDLE) && w_pend_nz;
    w_pend_nxt = r_pend;
    w_ovf_nxt  = r_ovf;
    if (w_inc && !w_dec) begin
      if (r_pend == PEND_MAX) begin
        w_ovf_nxt = 1'b1;
      end else begin
        w_pend_nxt = r_pend + PEND_ONE;
      end
    end else if (w_dec && !w_inc) begin
      w_pend_nxt = r_pend - PEND_ONE;
    end else begin
      w_pend_nxt = r_pend;
    end
    if (!w_ovf_nxt || r_ovf) begin
      if (bus.clr_ovf && !(w_inc && !w_dec && (r_pend == PEND_MAX))) begin
        w_ovf_nxt = 1'b0;
      end else begin
        w_ovf_nxt = w_ovf_nxt;
      end
    end else begin
      w_ovf_nxt = w_ovf_nxt;
    end
  end

  // State, prescaler and duration counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_presc <= 32'd0;
      r_dur   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_phase_clr) begin
        r_presc <= 32'd0;
        r_dur   <= 16'd0;
      end else if (w_slow_tick) begin
        r_presc <= 32'd0;
        r_dur   <= r_dur + 16'd1;
      end else begin
        r_presc <= r_presc + 32'd1;
        r_dur   <= r_dur;
      end
    end
  end

  // Pending counter and sticky overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= PEND_ZERO;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_ovf  <= w_ovf_nxt;
    end
  end

  assign bus.led     = (r_state == ST_ON);
  assign bus.busy    = (r_state != ST_IDLE) || w_pend_nz;
  assign bus.pending = r_pend;
  assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_event_indicator.sv
// Table-driven bench for event_indicator with CLK_DIV=4, ON_TICKS=3, GAP_TICKS=2, PEND_W=2.
// Adapts the retrigger expectations when EVT_RETRIGGER_EN is defined.
module tb_event_indicator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  event_indicator_if #(.PEND_W(2)) u_if ();

  event_indicator #(
    .CLK_DIV  (4),
    .ON_TICKS (3),
    .GAP_TICKS(2),
    .PEND_W   (2)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic tick;
    logic clr;
    logic led;
    logic busy;
    int   pend;
    logic ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic t, logic c, logic l, logic b, int p, logic o);
    vec_t v;
    v.tick = t; v.clr = c; v.led = l; v.busy = b; v.pend = p; v.ovf = o;
    tbl.push_back(v);
  endfunction

  function automatic void add_run(int n, logic l, logic b, int p, logic o);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, l, b, p, o);
  endfunction

  task automatic check(string name, int idx, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic expect_out(string name, int idx, logic l, logic b, int p, logic o);
    check({name, ".led"},     idx, int'(u_if.led),     int'(l));
    check({name, ".busy"},    idx, int'(u_if.busy),    int'(b));
    check({name, ".pending"}, idx, int'(u_if.pending), p);
    check({name, ".ovf"},     idx, int'(u_if.ovf),     int'(o));
  endtask

  task automatic step(logic t, logic c);
    u_if.tick_in = t;
    u_if.clr_ovf = c;
    @(posedge clk);
    #1;
  endtask

  // Assert rst mid-cycle and check outputs clear before any clock edge.
  task automatic async_reset_check(string name);
    u_if.tick_in = 1'b0;
    u_if.clr_ovf = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    expect_out(name, 0, 1'b0, 1'b0, 0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0);
      expect_out(name, i, 1'b0, 1'b0, 0, 1'b0);
    end
  endtask

  initial begin
    u_if.tick_in = 1'b0;
    u_if.clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 0, 1'b0, 1'b0, 0, 1'b0);
    rst = 1'b0;

    // Single event: 12 cycles ON, 8 cycles GAP, then idle.
    add(1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    add_run(11, 1'b1, 1'b1, 0, 1'b0);
    add_run(8,  1'b0, 1'b1, 0, 1'b0);
    add_run(2,  1'b0, 1'b0, 0, 1'b0);
`ifndef EVT_RETRIGGER_EN
    // Three events two cycles apart: three pulses separated by GAP + one idle cycle.
    add(1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0);
    add_run(7,  1'b1, 1'b1, 2, 1'b0);
    add_run(8,  1'b0, 1'b1, 2, 1'b0);
    add_run(1,  1'b0, 1'b1, 2, 1'b0);
    add_run(12, 1'b1, 1'b1, 1, 1'b0);
    add_run(8,  1'b0, 1'b1, 1, 1'b0);
    add_run(1,  1'b0, 1'b1, 1, 1'b0);
    add_run(12, 1'b1, 1'b1, 0, 1'b0);
    add_run(8,  1'b0, 1'b1, 0, 1'b0);
    add_run(2,  1'b0, 1'b0, 0, 1'b0);
    // Tick in the IDLE cycle that consumes pending=1: pending stays 1.
    add(1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    add_run(10, 1'b1, 1'b1, 1, 1'b0);
    add_run(8,  1'b0, 1'b1, 1, 1'b0);
    add_run(1,  1'b0, 1'b1, 1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    add_run(11, 1'b1, 1'b1, 1, 1'b0);
    add_run(8,  1'b0, 1'b1, 1, 1'b0);
    add_run(1,  1'b0, 1'b1, 1, 1'b0);
    add_run(12, 1'b1, 1'b1, 0, 1'b0);
    add_run(8,  1'b0, 1'b1, 0, 1'b0);
    add_run(2,  1'b0, 1'b0, 0, 1'b0);
    // Saturation at 3, ovf clear, and set beating clear.
    add(1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 3, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 3, 1'b1);
    add(1'b1, 1'b0, 1'b1, 1'b1, 3, 1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b1, 3, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b1);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].tick, tbl[i].clr);
      expect_out("vec", i, tbl[i].led, tbl[i].busy, tbl[i].pend, tbl[i].ovf);
    end

`ifndef EVT_RETRIGGER_EN
    async_reset_check("sat_rst");
`endif

    // Reset five cycles into ON.
    step(1'b1, 1'b0);
    for (int i = 1; i < 5; i++) begin
      step(1'b0, 1'b0);
      check("pre_rst.led", i, int'(u_if.led), 1);
    end
    async_reset_check("mid_rst");

    // Second tick eight cycles into ON: retrigger or queue depending on build.
    step(1'b1, 1'b0);
    for (int k = 2; k <= 8; k++) begin
      step(1'b0, 1'b0);
      check("retrig.led", k, int'(u_if.led), 1);
    end
    for (int k = 9; k <= 21; k++) begin
      step((k == 9) ? 1'b1 : 1'b0, 1'b0);
`ifdef EVT_RETRIGGER_EN
      check("retrig.led",  k, int'(u_if.led), (k <= 20) ? 1 : 0);
      check("retrig.pend", k, int'(u_if.pending), 0);
`else
      check("retrig.led",  k, int'(u_if.led), (k <= 12) ? 1 : 0);
      check("retrig.pend", k, int'(u_if.pending), 1);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
